// File: rtl/mips_regfile_mp.sv
// Parametrised multi-read-port register file for the MIPS multi-cycle datapath.
// Provides an optional hardwired zero register, same-cycle write-to-read bypass,
// and a per-register busy scoreboard that tracks outstanding multi-cycle producers.
module mips_regfile_mp #(
   parameter int NUM_REGS     = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_RD_PORTS = 2,
   parameter int ZERO_REG_EN  = 1,
   parameter int BYPASS_EN    = 1,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   localparam int AW = $clog2(NUM_REGS)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_RD_PORTS*AW-1:0]         rd_addr,
   output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_RD_PORTS-1:0]            rd_busy,
   input  logic                               wr_en,
   input  logic [AW-1:0]                      wr_addr,
   input  logic [DATA_WIDTH-1:0]              wr_data,
   input  logic                               busy_set,
   input  logic [AW-1:0]                      busy_addr,
   output logic [NUM_REGS-1:0]                busy
);

   // Depth expressed at address width plus one bit, so that a depth equal to a
   // power of two is still representable and range checks stay width-matched.
   localparam logic [AW:0] DEPTH = (AW+1)'(NUM_REGS);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   logic wr_in_range;
   logic wr_is_zero;
   logic wr_ok;
   logic bs_in_range;
   logic bs_is_zero;
   logic bs_ok;

   // Qualify the write and busy-set requests: out-of-range addresses and the
   // hardwired zero register are silently dropped.
   always_comb begin
      wr_in_range = ({1'b0, wr_addr} < DEPTH);
      wr_is_zero  = (ZERO_REG_EN != 0) && (wr_addr == '0);
      wr_ok       = wr_en && wr_in_range && !wr_is_zero;
      bs_in_range = ({1'b0, busy_addr} < DEPTH);
      bs_is_zero  = (ZERO_REG_EN != 0) && (busy_addr == '0);
      bs_ok       = busy_set && bs_in_range && !bs_is_zero;
   end

   // Register storage: reset wins over everything, otherwise a qualified write
   // updates the single addressed register.
   always_ff @(posedge clk) begin
      for (int r = 0; r < NUM_REGS; r++) begin
         if (rst) begin
            regs[r] <= RESET_VALUE;
         end else if (wr_ok && (wr_addr == AW'(r))) begin
            regs[r] <= wr_data;
         end
      end
   end

   // Busy scoreboard: a newly claimed producer takes priority over a write
   // retiring the previous producer of the same register.
   always_ff @(posedge clk) begin
      for (int r = 0; r < NUM_REGS; r++) begin
         if (rst) begin
            busy[r] <= 1'b0;
         end else if (bs_ok && (busy_addr == AW'(r))) begin
            busy[r] <= 1'b1;
         end else if (wr_ok && (wr_addr == AW'(r))) begin
            busy[r] <= 1'b0;
         end
      end
   end

   genvar p;
   generate
      for (p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_port
         logic [AW-1:0]         ra;
         logic                  ra_valid;
         logic [DATA_WIDTH-1:0] port_data;
         logic                  port_busy;

         assign ra = rd_addr[p*AW +: AW];

         // Combinational read with bypass: an in-flight qualified write to the
         // same address is forwarded and therefore no longer reported as busy.
         always_comb begin
            ra_valid  = ({1'b0, ra} < DEPTH) && !((ZERO_REG_EN != 0) && (ra == '0));
            port_data = '0;
            port_busy = 1'b0;
            if (ra_valid) begin
               for (int r = 0; r < NUM_REGS; r++) begin
                  if (ra == AW'(r)) begin
                     port_data = regs[r];
                     port_busy = busy[r];
                  end
               end
               if ((BYPASS_EN != 0) && wr_ok && (wr_addr == ra)) begin
                  port_data = wr_data;
                  port_busy = 1'b0;
               end
            end
         end

         assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = port_data;
         assign rd_busy[p]                          = port_busy;
      end
   endgenerate

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed testbench for mips_regfile_mp. Three instances share one stimulus
// stream: default configuration, bypass disabled, and a 24-entry register file.
module tb_mips_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rd_addr;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        busy_set;
   logic [4:0]  busy_addr;

   logic [63:0] rd_data_a, rd_data_b, rd_data_c;
   logic [1:0]  rd_busy_a, rd_busy_b, rd_busy_c;
   logic [31:0] busy_a, busy_b;
   logic [23:0] busy_c;

   int num_checks = 0;
   int num_fail   = 0;

   always #5 clk = ~clk;

   mips_regfile_mp dut_a (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy_set(busy_set), .busy_addr(busy_addr), .busy(busy_a)
   );

   mips_regfile_mp #(.BYPASS_EN(0)) dut_b (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy_set(busy_set), .busy_addr(busy_addr), .busy(busy_b)
   );

   mips_regfile_mp #(.NUM_REGS(24)) dut_c (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy_set(busy_set), .busy_addr(busy_addr), .busy(busy_c)
   );

   task automatic applyStimulus(input logic r, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic bs, input logic [4:0] ba,
                                input logic [9:0] ra);
      rst       = r;
      wr_en     = we;
      wr_addr   = wa;
      wr_data   = wd;
      busy_set  = bs;
      busy_addr = ba;
      rd_addr   = ra;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      num_checks++;
      assert (observed === expected) else begin
         num_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      $display("[TB] start");
      applyStimulus(1, 0, 0, 0, 0, 0, {5'd5, 5'd5});
      tick();
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, {5'd5, 5'd5});
      checkOutput("init_busy", 64'(busy_a), 64'h0);
      checkOutput("init_rd", rd_data_a, 64'h0);

      // Reset: load r5, mark r4 busy, then reset while a write and busy-set are requested
      applyStimulus(0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd4, {5'd5, 5'd5});
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, {5'd5, 5'd5});
      checkOutput("pre_reset_r5", rd_data_a, {32'hDEADBEEF, 32'hDEADBEEF});
      checkOutput("pre_reset_busy", 64'(busy_a), 64'h10);
      applyStimulus(1, 1, 5'd5, 32'h0000CAFE, 1, 5'd6, {5'd5, 5'd5});
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, {5'd5, 5'd5});
      checkOutput("post_reset_r5", rd_data_a, 64'h0);
      checkOutput("post_reset_busy", 64'(busy_a), 64'h0);
      checkOutput("post_reset_busy24", 64'(busy_c), 64'h0);

      // Zero register: write and busy-set on r0 are ignored, no bypass either
      applyStimulus(0, 1, 5'd0, 32'h00001234, 1, 5'd0, {5'd0, 5'd0});
      checkOutput("zero_bypass", rd_data_a, 64'h0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, {5'd0, 5'd0});
      checkOutput("zero_read", rd_data_a, 64'h0);
      checkOutput("zero_read_nb", rd_data_b, 64'h0);
      checkOutput("zero_busy", 64'(busy_a), 64'h0);

      // Bypass: old value 0x11111111 in r7, then write 0xA5A5A5A5 while both ports read r7
      applyStimulus(0, 1, 5'd7, 32'h11111111, 0, 0, {5'd7, 5'd7});
      tick();
      applyStimulus(0, 1, 5'd7, 32'hA5A5A5A5, 0, 0, {5'd7, 5'd7});
      checkOutput("bypass_on", rd_data_a, {32'hA5A5A5A5, 32'hA5A5A5A5});
      checkOutput("bypass_off_old", rd_data_b, {32'h11111111, 32'h11111111});
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, {5'd7, 5'd7});
      checkOutput("bypass_off_new", rd_data_b, {32'hA5A5A5A5, 32'hA5A5A5A5});

      // Scoreboard: claim r9, hold for three edges, then retire with a write of 0x55
      applyStimulus(0, 0, 0, 0, 1, 5'd9, {5'd9, 5'd7});
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, {5'd9, 5'd7});
      checkOutput("busy_r9", 64'(busy_a), 64'h200);
      checkOutput("rd_busy_r9", 64'(rd_busy_a), 64'h2);
      tick();
      tick();
      applyStimulus(0, 1, 5'd9, 32'h00000055, 0, 0, {5'd9, 5'd7});
      checkOutput("rd_busy_bypass", 64'(rd_busy_a), 64'h0);
      checkOutput("rd_busy_nobypass", 64'(rd_busy_b), 64'h2);
      checkOutput("rd_r9_bypass", rd_data_a, {32'h00000055, 32'hA5A5A5A5});
      checkOutput("busy_before_clear", 64'(busy_a), 64'h200);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, {5'd9, 5'd7});
      checkOutput("busy_cleared", 64'(busy_a), 64'h0);
      checkOutput("rd_r9_after", rd_data_a, {32'h00000055, 32'hA5A5A5A5});

      // Collision: busy-set and write to r3 on the same edge, set wins
      applyStimulus(0, 1, 5'd3, 32'h00000077, 1, 5'd3, {5'd3, 5'd3});
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, {5'd3, 5'd3});
      checkOutput("collide_data", rd_data_a, {32'h00000077, 32'h00000077});
      checkOutput("collide_busy", 64'(busy_a), 64'h8);
      checkOutput("collide_rd_busy", 64'(rd_busy_a), 64'h3);

      // Depth 24: address 30 is out of range there but valid in the 32-entry file
      applyStimulus(0, 1, 5'd30, 32'hFFFFFFFF, 1, 5'd30, {5'd3, 5'd30});
      checkOutput("oor_bypass24", rd_data_c, {32'h00000077, 32'h0});
      checkOutput("oor_rd_busy24", 64'(rd_busy_c), 64'h2);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, {5'd3, 5'd30});
      checkOutput("oor_read24", rd_data_c, {32'h00000077, 32'h0});
      checkOutput("oor_rd_busy24_after", 64'(rd_busy_c), 64'h2);
      checkOutput("oor_busy24", 64'(busy_c), 64'h8);
      checkOutput("r30_depth32", rd_data_a, {32'h00000077, 32'hFFFFFFFF});
      checkOutput("busy_depth32", 64'(busy_a), 64'h40000008);
      applyStimulus(0, 0, 0, 0, 0, 0, {5'd7, 5'd5});
      checkOutput("regs24_intact", rd_data_c, {32'hA5A5A5A5, 32'h0});

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

endmodule
